ram_arbiter: RTL
================

# ram_arbiter

Arbitrates the single-port program/data RAM of the 16-bit RISC core between three requesters: the external program loader, the core's memory stage (load/store) and instruction fetch. One grant per access, req/gnt handshake per requester, read data returned with a fixed latency. Sits between the RAM and the PC/CU datapath, replacing the direct PC-to-RAM address connection and the tied-off write port.

## Interface
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, RAM read latency in cycles (1..3)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ldr_req / dat_req / fet_req  in  1 each  access request, held until gnt
- ldr_we / dat_we  in  1 each  write enable (fetch is read-only)
- ldr_addr / dat_addr / fet_addr  in  AW each  address
- ldr_wdata / dat_wdata  in  DW each  write data
- ldr_gnt / dat_gnt / fet_gnt  out  1 each  access accepted this cycle
- ldr_rvalid / dat_rvalid / fet_rvalid  out  1 each  read data valid, 1-cycle pulse
- rdata  out  DW  read data, shared, qualified by the rvalid lines
- owner  out  2  id of current or last granted requester (0 ldr, 1 dat, 2 fet, 3 none)
- busy  out  1  read in flight
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data

## Operation
- States: IDLE, RD_WAIT.
- IDLE: if any req, grant exactly one (combinational, same cycle); drive ram_addr/ram_din from winner; ram_we = winner_we & gnt.
- Priority: ldr > dat > fet.
- Granted write: completes at that clock edge; remain IDLE; next grant possible next cycle.
- Granted read: go to RD_WAIT, load latency counter with RD_LAT; capture owner.
- RD_WAIT: no grants; ram_we=0; counter decrements each cycle; when it reaches 0, rdata <= ram_dout, pulse rvalid of owner, return IDLE.
- No grant while no req: ram_we=0, ram_addr/ram_din hold last values, owner unchanged.
- Requester dropping req before gnt is legal; no access performed.

## Timing
- Reset values: all gnt 0, all rvalid 0, rdata 0, owner 3, busy 0, ram_we 0, ram_addr 0, ram_din 0, state IDLE.
- Write: gnt and RAM write in cycle N; no response pulse.
- Read: gnt in cycle N; rvalid and rdata valid in cycle N+RD_LAT+1 (registered); next grant earliest in that same cycle.
- Sustained read throughput: one per RD_LAT+1 cycles; writes one per cycle.
- Simultaneous req: priority (or round-robin, see Configuration) decides; losers wait with req held, gnt 0.
- rst during RD_WAIT: pending read discarded, no rvalid ever issued for it.
- busy = (state == RD_WAIT).

## Configuration
- RAM_ARB_RR_EN defined: dat and fet share round-robin — when both request and ldr does not, the one not granted last among {dat, fet} wins; pointer updates on every dat/fet grant; reset value favours dat. ldr stays strictly highest.
- Not defined: fixed priority ldr > dat > fet; fet may starve under continuous dat traffic.

## Structure
- Package ram_arb_pkg: requester id constants (ID_LDR=0, ID_DAT=1, ID_FET=2, ID_NONE=3), state enum (IDLE, RD_WAIT).
- Sub-module ram_arb_prio: pure combinational grant encoder (req vector, rr pointer -> one-hot grant); arbiter top holds FSM, latency counter, rdata/owner registers and RAM muxing.

## Test plan
- Reset: assert rst with fet_req=1 -> all gnt/rvalid 0, owner 3, ram_we 0; release -> fet_gnt in first IDLE cycle.
- Single read: fet_req, fet_addr=0x0004, RAM[4]=0xA5C3, RD_LAT=1 -> fet_gnt cycle N, fet_rvalid with rdata=0xA5C3 cycle N+2.
- Write then read: dat write 0x1234 to 0x0010, then dat read 0x0010 -> write gnt N, read gnt N+1, dat_rvalid rdata=0x1234 at N+3.
- Conflict: ldr, dat, fet all req in same cycle -> ldr_gnt first; then dat; fet last (fixed priority build).
- Round-robin (RAM_ARB_RR_EN): dat and fet continuously request reads -> grants alternate dat, fet, dat, fet; none starved over 20 grants.
- Reset mid-read: rst pulse during RD_WAIT after dat read gnt -> no dat_rvalid, busy 0, next grant accepted normally after release.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter.
// Contents: requester id constants (reported on the owner port), grant vector
// bit positions and the arbiter state type.
package ram_arb_pkg;

  localparam logic [1:0] ID_LDR  = 2'd0;
  localparam logic [1:0] ID_DAT  = 2'd1;
  localparam logic [1:0] ID_FET  = 2'd2;
  localparam logic [1:0] ID_NONE = 2'd3;

  // Bit positions in the {fet, dat, ldr} request/grant vectors
  localparam int unsigned G_LDR = 0;
  localparam int unsigned G_DAT = 1;
  localparam int unsigned G_FET = 2;

  typedef enum logic {IDLE, RD_WAIT} state_e;

endpackage

// File: rtl/ram_arb_prio.sv
// Combinational grant encoder for the RAM arbiter.
// Ports:
//   req    - request vector {fet, dat, ldr}
//   rr_fet - 1 when fet is favoured over dat in a dat/fet tie
//   gnt    - one-hot (or zero) grant vector, same bit order as req
// ldr always wins; a dat/fet tie is resolved by rr_fet (tied low for fixed
// priority, which makes dat win).
module ram_arb_prio (
  input  logic [2:0] req,
  input  logic       rr_fet,
  output logic [2:0] gnt
);
  import ram_arb_pkg::*;

  always_comb begin
    gnt = '0;
    if (req[G_LDR]) begin
      gnt[G_LDR] = 1'b1;
    end else if (req[G_DAT] && req[G_FET]) begin
      if (rr_fet) gnt[G_FET] = 1'b1;
      else        gnt[G_DAT] = 1'b1;
    end else if (req[G_DAT]) begin
      gnt[G_DAT] = 1'b1;
    end else if (req[G_FET]) begin
      gnt[G_FET] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port program/data RAM arbiter for the 16-bit RISC core.
// Requesters: program loader (ldr), memory stage (dat), instruction fetch (fet).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   *_req/*_we/*_addr/*_wdata - per-requester access request (fet read-only)
//   *_gnt                    - access accepted this cycle (combinational)
//   *_rvalid, rdata          - registered read response, 1-cycle pulse
//   owner                    - id of current/last granted requester (3 = none)
//   busy                     - read in flight
//   ram_we/ram_addr/ram_din/ram_dout - RAM port
// Build option: RAM_ARB_RR_EN makes dat and fet share round-robin priority;
// without it priority is fixed ldr > dat > fet.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ldr_req,
  input  logic          dat_req,
  input  logic          fet_req,
  input  logic          ldr_we,
  input  logic          dat_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [AW-1:0] dat_addr,
  input  logic [AW-1:0] fet_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic [DW-1:0] dat_wdata,
  output logic          ldr_gnt,
  output logic          dat_gnt,
  output logic          fet_gnt,
  output logic          ldr_rvalid,
  output logic          dat_rvalid,
  output logic          fet_rvalid,
  output logic [DW-1:0] rdata,
  output logic [1:0]    owner,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_e        state_q;
  logic [1:0]    cnt_q;
  logic [1:0]    owner_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] din_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    rvalid_q;

  logic [2:0]    req, gnt_raw, gnt;
  logic          rr_fet, grant_en, any_gnt;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_din;
  logic [1:0]    win_id;

  assign req = {fet_req, dat_req, ldr_req};

  ram_arb_prio u_prio (
    .req    (req),
    .rr_fet (rr_fet),
    .gnt    (gnt_raw)
  );

  // Grants only in IDLE; rst also masks them so nothing reaches the RAM in reset.
  assign grant_en = (state_q == IDLE) && !rst;
  assign gnt      = grant_en ? gnt_raw : 3'b000;
  assign any_gnt  = |gnt;

  // Winner mux; with no grant the RAM address/data hold their last values.
  always_comb begin
    win_we   = 1'b0;
    win_addr = addr_q;
    win_din  = din_q;
    win_id   = owner_q;
    unique case (1'b1)
      gnt[G_LDR]: begin
        win_we   = ldr_we;
        win_addr = ldr_addr;
        win_din  = ldr_wdata;
        win_id   = ID_LDR;
      end
      gnt[G_DAT]: begin
        win_we   = dat_we;
        win_addr = dat_addr;
        win_din  = dat_wdata;
        win_id   = ID_DAT;
      end
      gnt[G_FET]: begin
        win_addr = fet_addr;
        win_id   = ID_FET;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      owner_q  <= ID_NONE;
      rdata_q  <= '0;
      din_q    <= '0;
      addr_q   <= '0;
      rvalid_q <= 3'b000;
    end else begin
      rvalid_q <= 3'b000;
      if (any_gnt) begin
        owner_q <= win_id;
        addr_q  <= win_addr;
        din_q   <= win_din;
      end
      case (state_q)
        IDLE: begin
          if (any_gnt && !win_we) begin
            state_q <= RD_WAIT;
            cnt_q   <= RD_LAT[1:0];
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          // Last wait cycle: capture RAM data so rvalid lands RD_LAT+1 after gnt
          if (cnt_q == 2'd1) begin
            rdata_q  <= ram_dout;
            rvalid_q <= 3'b001 << owner_q;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RAM_ARB_RR_EN
  // 1 = fet goes first on the next dat/fet tie; reset favours dat.
  logic rr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (gnt[G_DAT]) begin
      rr_q <= 1'b1;
    end else if (gnt[G_FET]) begin
      rr_q <= 1'b0;
    end
  end
  assign rr_fet = rr_q;
`else
  assign rr_fet = 1'b0;
`endif

  assign ldr_gnt    = gnt[G_LDR];
  assign dat_gnt    = gnt[G_DAT];
  assign fet_gnt    = gnt[G_FET];
  assign ldr_rvalid = rvalid_q[G_LDR];
  assign dat_rvalid = rvalid_q[G_DAT];
  assign fet_rvalid = rvalid_q[G_FET];
  assign rdata      = rdata_q;
  assign owner      = owner_q;
  assign busy       = (state_q == RD_WAIT);
  assign ram_we     = win_we;
  assign ram_addr   = win_addr;
  assign ram_din    = win_din;

endmodule
